// File: rtl/ram_hs_pkg.sv
// Shared width helpers and default configuration for the ram_hs data RAM.
package ram_hs_pkg;

    localparam int unsigned RHS_DW        = 32;
    localparam int unsigned RHS_AW        = 32;
    localparam int unsigned RHS_MEM_NUM   = 4096;
    localparam int unsigned RHS_RD_LAT    = 1;
    localparam int unsigned RHS_RSP_DEPTH = 2;

    // Number of byte lanes in a data word.
    function automatic int unsigned nb_f(input int unsigned dw);
        return dw / 8;
    endfunction

    // Width of the byte offset stripped from an address.
    function automatic int unsigned off_w_f(input int unsigned dw);
        return $clog2(dw / 8);
    endfunction

    // Word index width; never zero so a single-word memory still has a port.
    function automatic int unsigned idx_w_f(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold 0..d inclusive.
    function automatic int unsigned cnt_w_f(input int unsigned d);
        return $clog2(d + 1);
    endfunction

    // Pointer width for a d-entry ring; never zero.
    function automatic int unsigned ptr_w_f(input int unsigned d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/ram_hs_rsp_fifo.sv
// Response buffer: ring FIFO with empty bypass, occupancy count and wrapping pointers.
module rsp_fifo
    import ram_hs_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 33
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_push_valid,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    localparam int unsigned PW = ptr_w_f(DEPTH);
    localparam int unsigned CW = cnt_w_f(DEPTH);

    logic [W-1:0]  r_buf [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_empty = (r_cnt == '0);
    assign o_valid = !w_empty || i_push_valid;
    assign o_data  = w_empty ? i_push_data : r_buf[r_rptr];
    assign w_pop   = !w_empty && i_pop_ready;
    // An incoming item that is consumed while the buffer is empty passes straight through.
    assign w_push  = i_push_valid && !(w_empty && i_pop_ready);

    // Storage write; contents need no reset since r_cnt qualifies them.
    always_ff @(posedge clk) begin
        if (w_push) r_buf[r_wptr] <= i_push_data;
    end

    // Pointer and occupancy update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
            else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(w_push && !w_pop && (r_cnt == CW'(DEPTH))));

endmodule

// File: rtl/ram_hs.sv
// Single-clock data RAM: byte-strobed write port, valid/ready read port with
// configurable latency and an in-order response buffer.
// Optional build macro RAM_HS_FWD_EN: forward a same-cycle write to the word being read.
module ram_hs
    import ram_hs_pkg::*;
#(
    parameter int unsigned DW        = RHS_DW,
    parameter int unsigned AW        = RHS_AW,
    parameter int unsigned MEM_NUM   = RHS_MEM_NUM,
    parameter int unsigned RD_LAT    = RHS_RD_LAT,
    parameter int unsigned RSP_DEPTH = RHS_RSP_DEPTH
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [DW/8-1:0]     w_strb,
    input  logic [AW-1:0]       w_addr,
    input  logic [DW-1:0]       w_data,
    input  logic                r_req_valid,
    output logic                r_req_ready,
    input  logic [AW-1:0]       r_addr,
    output logic                r_rsp_valid,
    input  logic                r_rsp_ready,
    output logic [DW-1:0]       r_data,
    output logic                r_err
);

    localparam int unsigned NB    = nb_f(DW);
    localparam int unsigned OFF_W = off_w_f(DW);
    localparam int unsigned IDX_W = idx_w_f(MEM_NUM);
    localparam int unsigned CNT_W = cnt_w_f(RSP_DEPTH);
    localparam int unsigned AIW   = AW - OFF_W;
    localparam logic [AIW-1:0]   MEM_LIM = AIW'(MEM_NUM);
    localparam logic [CNT_W-1:0] CREDITS = CNT_W'(RSP_DEPTH);

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } rsp_s;

    logic [DW-1:0]    r_mem [MEM_NUM];
    logic [AIW-1:0]   w_widx;
    logic [AIW-1:0]   w_ridx;
    logic             w_wr_en;
    logic             w_rd_inr;
    logic             w_acc;
    logic             w_pop;
    logic [DW-1:0]    w_rd_word;
    rsp_s             r_s1;
    logic             r_s1_vld;
    rsp_s             w_ls;
    logic             w_ls_vld;
    rsp_s             w_rsp;
    logic             w_rsp_vld;
    logic [CNT_W-1:0] r_out;
    logic             w_unused;

    assign w_widx   = w_addr[AW-1:OFF_W];
    assign w_ridx   = r_addr[AW-1:OFF_W];
    assign w_wr_en  = (|w_strb) && (w_widx < MEM_LIM);
    assign w_rd_inr = (w_ridx < MEM_LIM);
    assign w_acc    = r_req_valid && r_req_ready;
    assign w_pop    = w_rsp_vld && r_rsp_ready;
    assign w_unused = ^{w_addr[OFF_W-1:0], r_addr[OFF_W-1:0]};

    // Credit check uses only the registered count, so ready never depends on this cycle's inputs.
    assign r_req_ready = (r_out < CREDITS);

    // Byte-lane write into the array; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (w_strb[k]) r_mem[w_widx[IDX_W-1:0]][8*k +: 8] <= w_data[8*k +: 8];
            end
        end
    end

    // Read word selection, zero when out of range.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_inr) begin
            w_rd_word = r_mem[w_ridx[IDX_W-1:0]];
`ifdef RAM_HS_FWD_EN
            if (w_wr_en && (w_widx == w_ridx)) begin
                for (int unsigned k = 0; k < NB; k++) begin
                    if (w_strb[k]) w_rd_word[8*k +: 8] = w_data[8*k +: 8];
                end
            end
`endif
        end
    end

    // First read pipeline stage, loaded on request accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_vld <= 1'b0;
            r_s1     <= '0;
        end else begin
            r_s1_vld <= w_acc;
            if (w_acc) r_s1 <= '{data: w_rd_word, err: !w_rd_inr};
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        rsp_s r_s2;
        logic r_s2_vld;

        // Optional second read pipeline stage.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_s2_vld <= 1'b0;
                r_s2     <= '0;
            end else begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) r_s2 <= r_s1;
            end
        end

        assign w_ls_vld = r_s2_vld;
        assign w_ls     = r_s2;
    end else begin : g_lat1
        assign w_ls_vld = r_s1_vld;
        assign w_ls     = r_s1;
    end

    rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .W     (DW + 1)
    ) u_rsp_fifo (
        .clk          (clk),
        .rstn         (rstn),
        .i_push_valid (w_ls_vld),
        .i_push_data  (w_ls),
        .i_pop_ready  (r_rsp_ready),
        .o_valid      (w_rsp_vld),
        .o_data       (w_rsp)
    );

    assign r_rsp_valid = w_rsp_vld;
    assign r_data      = w_rsp_vld ? w_rsp.data : '0;
    assign r_err       = w_rsp_vld && w_rsp.err;

    // Outstanding reads: in flight plus buffered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out <= '0;
        end else if (w_acc && !w_pop) begin
            r_out <= r_out + CNT_W'(1);
        end else if (!w_acc && w_pop) begin
            r_out <= r_out - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ram_hs.sv
// Directed self-checking bench for ram_hs (DW=32, MEM_NUM=4096, RD_LAT=1, RSP_DEPTH=2).
module tb_ram_hs;

    logic        clk;
    logic        rstn;
    logic [3:0]  w_strb;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        r_req_valid;
    logic        r_req_ready;
    logic [31:0] r_addr;
    logic        r_rsp_valid;
    logic        r_rsp_ready;
    logic [31:0] r_data;
    logic        r_err;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Backpressure scenario, one entry per cycle.
    int          t3_vin  [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    int          t3_addr [9] = '{0, 4, 8, 8, 8, 8, 12, 0, 0};
    int          t3_rin  [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
    int          t3_rdy  [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    int          t3_vld  [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    int          t3_dat  [9] = '{0, 1, 1, 1, 1, 2, 3, 4, 0};

    ram_hs #(
        .DW        (32),
        .AW        (32),
        .MEM_NUM   (4096),
        .RD_LAT    (1),
        .RSP_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .w_strb      (w_strb),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .r_req_valid (r_req_valid),
        .r_req_ready (r_req_ready),
        .r_addr      (r_addr),
        .r_rsp_valid (r_rsp_valid),
        .r_rsp_ready (r_rsp_ready),
        .r_data      (r_data),
        .r_err       (r_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        w_addr = addr;
        w_data = data;
        w_strb = strb;
        next_cycle();
        w_strb = '0;
    endtask

    task automatic read_one(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic exp_err);
        r_rsp_ready = 1'b1;
        r_req_valid = 1'b1;
        r_addr      = addr;
        next_cycle();
        r_req_valid = 1'b0;
        @(negedge clk);
        check({tag, "_vld"}, r_rsp_valid, 1);
        check({tag, "_data"}, r_data, exp_data);
        check({tag, "_err"}, r_err, exp_err);
        next_cycle();
    endtask

    initial begin
        rstn        = 1'b0;
        w_strb      = '0;
        w_addr      = '0;
        w_data      = '0;
        r_req_valid = 1'b0;
        r_addr      = '0;
        r_rsp_ready = 1'b0;
        #2;
        check("rst_ready", r_req_ready, 1);
        check("rst_valid", r_rsp_valid, 0);
        check("rst_data", r_data, 0);
        check("rst_err", r_err, 0);
        @(negedge clk);
        rstn = 1'b1;
        next_cycle();

        // 1: fill words 0..15 with i+1, stream them back at full rate
        for (int i = 0; i < 16; i++) wr(32'(4 * i), 32'(i + 1), 4'b1111);
        r_rsp_ready = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            r_req_valid = (i < 16);
            r_addr      = 32'(4 * i);
            @(negedge clk);
            if (i < 16) check("t1_ready", r_req_ready, 1);
            if (i == 0) begin
                check("t1_first_idle", r_rsp_valid, 0);
            end else begin
                check("t1_vld", r_rsp_valid, 1);
                check("t1_data", r_data, 64'(i));
                check("t1_err", r_err, 0);
            end
            next_cycle();
        end
        r_req_valid = 1'b0;

        // 2: byte-lane merge
        wr(32'h10, 32'hAABBCCDD, 4'b1111);
        wr(32'h10, 32'h11223344, 4'b0101);
        read_one("t2", 32'h10, 32'hAA22CC44, 1'b0);

        // 3: backpressure with credit limit of two
        for (int c = 0; c < 9; c++) begin
            r_req_valid = (t3_vin[c] != 0);
            r_addr      = 32'(t3_addr[c]);
            r_rsp_ready = (t3_rin[c] != 0);
            @(negedge clk);
            check("t3_req_ready", r_req_ready, 64'(t3_rdy[c]));
            check("t3_rsp_valid", r_rsp_valid, 64'(t3_vld[c]));
            check("t3_rsp_data", r_data, 64'(t3_dat[c]));
            next_cycle();
        end

        // 4: out-of-range read, then dropped out-of-range write
        read_one("t4_oor", 32'd16384, 32'h0, 1'b1);
        wr(32'd16384, 32'hFFFFFFFF, 4'b1111);
        read_one("t4_idx0", 32'h0, 32'h1, 1'b0);

        // 5: same-cycle read and write to one word
        wr(32'h20, 32'h0, 4'b1111);
        r_rsp_ready = 1'b1;
        w_addr      = 32'h20;
        w_data      = 32'hDEADBEEF;
        w_strb      = 4'b1111;
        r_req_valid = 1'b1;
        r_addr      = 32'h20;
        next_cycle();
        w_strb      = '0;
        r_req_valid = 1'b0;
        @(negedge clk);
        check("t5_vld", r_rsp_valid, 1);
`ifdef RAM_HS_FWD_EN
        check("t5_same_cycle", r_data, 32'hDEADBEEF);
`else
        check("t5_same_cycle", r_data, 32'h0);
`endif
        next_cycle();
        read_one("t5_after", 32'h20, 32'hDEADBEEF, 1'b0);

        // 6: reset with two reads outstanding
        r_rsp_ready = 1'b0;
        r_req_valid = 1'b1;
        r_addr      = 32'h0;
        next_cycle();
        r_addr      = 32'h4;
        next_cycle();
        r_req_valid = 1'b0;
        @(negedge clk);
        check("t6_pre_vld", r_rsp_valid, 1);
        check("t6_pre_ready", r_req_ready, 0);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_rst_ready", r_req_ready, 1);
        check("t6_rst_valid", r_rsp_valid, 0);
        check("t6_rst_data", r_data, 0);
        check("t6_rst_err", r_err, 0);
        @(negedge clk);
        rstn = 1'b1;
        next_cycle();
        r_rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t6_no_stale", r_rsp_valid, 0);
            check("t6_ready", r_req_ready, 1);
            next_cycle();
        end
        read_one("t6_after", 32'h10, 32'hAA22CC44, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_hs.md
Name: ram_hs

Overview:
Parametrised single-clock data RAM, the successor to the basic ram block for the core's data memory.
- One write port: byte-lane strobes, always accepted.
- One read port: valid/ready request and response handshake, configurable read pipeline latency and a response buffer, so the LSU can stall without losing data.
- Out-of-range reads are flagged; writes to the word being read in the same cycle can optionally be forwarded.

Parameters:
DW, 32, data width in bits; multiple of 8; NB = DW/8 byte lanes.
AW, 32, byte-address width.
MEM_NUM, 4096, number of DW-bit words.
RD_LAT, 1, read latency from request accept to earliest response; legal values 1 or 2.
RSP_DEPTH, 2, maximum outstanding reads (in flight plus buffered); must be ≥ RD_LAT; full throughput needs ≥ RD_LAT+1.

Ports:
clk  in  1  clock, rising edge.
rstn  in  1  asynchronous active-low reset.
w_strb  in  NB  byte-lane write enables; any bit set means a write this cycle.
w_addr  in  AW  write byte address.
w_data  in  DW  write data; lane k is bits [8k+7:8k].
r_req_valid  in  1  read request valid.
r_req_ready  out  1  read request accepted when valid & ready.
r_addr  in  AW  read byte address.
r_rsp_valid  out  1  read response valid.
r_rsp_ready  in  1  consumer accepts the response.
r_data  out  DW  read data; 0 whenever r_rsp_valid=0.
r_err  out  1  response was out of range; 0 whenever r_rsp_valid=0.

Behaviour:
- Interface: one clock (clk); asynchronous active-low reset (rstn).
- Reset values: r_req_ready=1, r_rsp_valid=0, r_data=0, r_err=0.
  - Pipeline stages, response buffer and outstanding counter clear.
  - Memory contents are not reset.
- Reset mid-operation drops all in-flight and buffered reads. No response is produced for them after reset release.
- Word index = addr >> log2(NB). Low address bits are ignored.
- Write:
  - When index < MEM_NUM and w_strb != 0, lanes with strobe set are updated at the clock edge. Other lanes are unchanged.
  - When index ≥ MEM_NUM, the write is silently dropped.
- Read accept: on r_req_valid & r_req_ready at cycle T, the memory word is read and captured into stage 1 at the end of T.
  - RD_LAT=2 adds stage 2.
  - The response is presented in cycle T+RD_LAT.
- Out of range: index ≥ MEM_NUM gives a response with r_data=0 and r_err=1.
- Response path:
  - Last pipeline stage feeds a FIFO of depth RSP_DEPTH with bypass.
  - When the FIFO is empty, the last stage drives the outputs directly.
  - If r_rsp_ready=0, the response is pushed into the FIFO.
  - Responses are returned strictly in request order.
- Credit control:
  - Counter `outstanding` (width clog2(RSP_DEPTH+1)): +1 on request accept, −1 on response handshake, both in the same cycle → unchanged.
  - r_req_ready = (outstanding < RSP_DEPTH), decoded from registered state only. There is no combinational path from r_rsp_ready or r_req_valid.
  - The FIFO can never overflow. Overflow is an assertion failure.
- Boundary cases:
  - outstanding == RSP_DEPTH → r_req_ready=0 until a response is consumed; the request is accepted the cycle after.
  - FIFO empty and no stage valid → r_rsp_valid=0.
  - FIFO pointers wrap modulo RSP_DEPTH.
  - Request accept and response pop in the same cycle with a full FIFO is legal.
- Same-cycle read and write to the same index:
  - Without the optional feature: the read returns old data.
  - Writes in cycles after T are never visible to that read.

Optional Feature:
- RAM_HS_FWD_EN defined: a same-cycle write to the read index is forwarded byte-wise. The response has strobed lanes from w_data and other lanes from memory, i.e. write-first semantics.
- RAM_HS_FWD_EN undefined: read-first, old data returned, no forwarding logic.

Decomposition:
- Package ram_hs_pkg:
  - Width helper constants: NB, byte-offset width log2(NB), index width clog2(MEM_NUM), counter width clog2(RSP_DEPTH+1).
  - Response struct {data, err}.
- One sub-module, rsp_fifo: a parametrised depth/width FIFO with empty bypass, count and wrap-around pointers. ram_hs instantiates it for the response buffer.

Test Plan:
1. Reset, then write addr 4*i with data i+1, strb=4'b1111, for i=0..15; read back with r_rsp_ready=1 continuously.
   → response i arrives at T+RD_LAT with data i+1, err=0; r_req_ready stays 1 (full throughput, RD_LAT=1, RSP_DEPTH=2).
2. Byte lanes: write 32'hAABBCCDD to addr 0x10, then 32'h11223344 with strb=4'b0101.
   → read returns 32'hAA22CC44.
3. Backpressure: hold r_rsp_ready=0 and issue 4 reads.
   → exactly RSP_DEPTH=2 accepted, r_req_ready=0 afterwards; release ready → the two responses return in order, then 2 more accepted.
4. Out of range: read addr 4*4096 (index 4096).
   → r_data=0, r_err=1. Write to the same address → memory unchanged at index 0.
5. Same-cycle read/write at addr 0x20: old 32'h0, write 32'hDEADBEEF.
   → 32'h0 without RAM_HS_FWD_EN; 32'hDEADBEEF with it.
6. Assert rstn=0 with 2 reads in flight.
   → outputs return to reset values immediately; no stale response after release; next read returns correct data.
